piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first on serial_out.
- Bit order matches the codebase shift-register convention: the MSB exits first, so the block can drive a SISO chain or serial receiver directly.
- Bit advance is paced by a shift_en strobe, so the line can run below clk rate.
- Back-to-back words stream with no idle gap.

Parameters:
- WIDTH, 4, word width in bits; legal values are 2 or more.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- data_in  input  WIDTH  parallel word to transmit
- load_valid  input  1  data_in is valid
- load_ready  output  1  block can accept a word this cycle
- shift_en  input  1  bit-advance strobe; the current bit is held while low
- serial_out  output  1  serial data, MSB first
- frame_out  output  1  high while serial_out carries a valid data bit
- last_bit  output  1  high while serial_out carries bit 0 of the current word

Behaviour:
- Reset (rst high at a clk edge; rst has priority over all other inputs):
  - state=IDLE, shift_reg=0, bit_cnt=0.
  - Registered outputs serial_out=0 and frame_out=0 from the cycle after the edge.
  - load_ready=0 in any cycle where rst=1.
  - A frame in progress is aborted with no completion indication. A load_valid present during reset is ignored.
- State machine:
  - IDLE: load_ready=1. serial_out=0, frame_out=0.
  - SHIFT: a word is on the line. frame_out=1, serial_out=shift_reg[WIDTH-1].
- Handshake: a transfer occurs at an edge where load_valid&&load_ready=1. data_in is sampled only at that edge and may change freely otherwise.
- load_ready (combinational from registers and shift_en):
  - 1 in IDLE.
  - 1 in SHIFT only when bit_cnt==0 && shift_en==1, i.e. on the edge that retires the last bit.
  - 0 otherwise.
- Transfer accepted from IDLE:
  - shift_reg<=data_in, bit_cnt<=WIDTH-1, state<=SHIFT.
  - The MSB appears on serial_out in the next cycle; latency is 1 clk from the accepting edge.
  - Acceptance does not require shift_en.
- In SHIFT with shift_en=1 and bit_cnt>0: shift_reg<={shift_reg[WIDTH-2:0],1'b0}, bit_cnt<=bit_cnt-1.
- In SHIFT with shift_en=0: all state is held and serial_out is stable.
- In SHIFT with shift_en=1 and bit_cnt==0 (last bit retiring):
  - If load_valid=1: shift_reg<=data_in, bit_cnt<=WIDTH-1, stay in SHIFT. The next word's MSB follows the previous LSB with no gap and frame_out stays high.
  - Else: state<=IDLE, serial_out returns to 0, frame_out falls.
- A word occupies exactly WIDTH shift_en-qualified edges. Each bit is held for at least 1 clk.
- last_bit = (state==SHIFT) && (bit_cnt==0). Asserted for the full duration of the final bit.
- bit_cnt width is clog2(WIDTH). Counting is never below 0; there is no wrap.
- load_valid while load_ready=0 has no effect. The source must hold the word (valid/ready rule); the block does not buffer.
- shift_en in IDLE has no effect.

Test Plan:
- Basic frame (WIDTH=4, shift_en tied 1): rst for 2 clks, then load 4'b1011 → serial_out =1,0,1,1 on 4 consecutive cycles starting 1 clk after acceptance. frame_out is high those 4 cycles. last_bit is high on the 4th. Then IDLE with serial_out=0 and load_ready=1.
- Back-to-back: load_valid held high with 4'b1100 then 4'b0110 → 8 contiguous bits 1,1,0,0,0,1,1,0. frame_out is high for all 8 cycles with no gap. load_ready pulses exactly on the 4th-bit cycle of word 1.
- Pacing: shift_en high 1 cycle in every 3, load 4'b1001 → each bit held 3 clks. Total frame is 12 clks. load_ready stays 0 until the shift_en cycle of bit 0.
- Backpressure: load_valid asserted mid-frame with 4'b1111 → not accepted until the last-bit edge. The current word's bits are unchanged, then 1,1,1,1 follows.
- Reset mid-operation: rst asserted during bit 2 of 4'b1010 → next cycle serial_out=0, frame_out=0, last_bit=0. After rst drops, load_ready=1 and a fresh load of 4'b0001 transmits correctly.
- Idle hygiene: shift_en toggling and load_valid=0 in IDLE → serial_out, frame_out and last_bit stay 0 and the state does not leave IDLE.

Source files
------------

// File: rtl/piso_tx_if.sv
// Handshake and serial-line bundle for piso_tx.
// The source drives the word and pacing strobe; the transmitter drives ready and the line.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             serial_out;
  logic             frame_out;
  logic             last_bit;

  modport master (
    output data_in, load_valid, shift_en,
    input  load_ready, serial_out, frame_out, last_bit
  );

  modport slave (
    input  data_in, load_valid, shift_en,
    output load_ready, serial_out, frame_out, last_bit
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a word on valid/ready and shifts it out
// MSB first, one bit per shift_en strobe, streaming back-to-back words without a gap.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  piso_tx_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;

  assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_ZERO);
  // Ready is forced low during reset so a concurrent load_valid is never seen as a transfer.
  assign w_ready  = !rst && ((r_state == IDLE) || (w_last && bus.shift_en));
  assign w_accept = w_ready && bus.load_valid;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= {WIDTH{1'b0}};
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_shift_nxt = bus.data_in;
          w_cnt_nxt   = CNT_TOP;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (!bus.shift_en) begin
          w_state_nxt = SHIFT;
        end else if (r_cnt != CNT_ZERO) begin
          w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
          w_cnt_nxt   = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (w_accept) begin
          // Next word's MSB follows this LSB directly; frame stays up.
          w_shift_nxt = bus.data_in;
          w_cnt_nxt   = CNT_TOP;
        end else begin
          w_state_nxt = IDLE;
          w_shift_nxt = {WIDTH{1'b0}};
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_shift_nxt = {WIDTH{1'b0}};
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Outputs, decoded from the registered state only (plus shift_en for ready).
  always_comb begin
    bus.load_ready = w_ready;
    bus.last_bit   = w_last;
    case (r_state)
      IDLE: begin
        bus.serial_out = 1'b0;
        bus.frame_out  = 1'b0;
      end
      SHIFT: begin
        bus.serial_out = r_shift[WIDTH-1];
        bus.frame_out  = 1'b1;
      end
      default: begin
        bus.serial_out = 1'b0;
        bus.frame_out  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx (WIDTH=4): each cycle applies inputs at the falling edge
// and checks serial_out/frame_out/last_bit/load_ready against hand-computed values.
module tb_piso_tx;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   cyc_idx;

  piso_tx_if #(.WIDTH(WIDTH)) bus ();

  piso_tx #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // exp = {serial_out, frame_out, last_bit, load_ready}
  task automatic cyc(input logic r, input logic lv, input logic [WIDTH-1:0] d,
                     input logic se, input logic [3:0] exp_v);
    @(negedge clk);
    rst            = r;
    bus.load_valid = lv;
    bus.data_in    = d;
    bus.shift_en   = se;
    #1;
    check_val($sformatf("c%0d.serial_out", cyc_idx), {31'd0, bus.serial_out}, {31'd0, exp_v[3]});
    check_val($sformatf("c%0d.frame_out",  cyc_idx), {31'd0, bus.frame_out},  {31'd0, exp_v[2]});
    check_val($sformatf("c%0d.last_bit",   cyc_idx), {31'd0, bus.last_bit},   {31'd0, exp_v[1]});
    check_val($sformatf("c%0d.load_ready", cyc_idx), {31'd0, bus.load_ready}, {31'd0, exp_v[0]});
    cyc_idx++;
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    logic             se_v;
    n_checks       = 0;
    n_errors       = 0;
    cyc_idx        = 0;
    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.data_in    = 4'b0000;
    bus.shift_en   = 1'b0;

    // Reset for 2 clks; ready is low throughout.
    cyc(1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000);

    // Basic frame 1011 with shift_en tied high.
    cyc(1'b0, 1'b1, 4'b1011, 1'b1, 4'b0001);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1100);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0100);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1100);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1111);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0001);

    // Back-to-back 1100 then 0110: eight contiguous bits, ready pulses on word 1's last bit.
    cyc(1'b0, 1'b1, 4'b1100, 1'b1, 4'b0001);
    cyc(1'b0, 1'b1, 4'b0110, 1'b1, 4'b1100);
    cyc(1'b0, 1'b1, 4'b0110, 1'b1, 4'b1100);
    cyc(1'b0, 1'b1, 4'b0110, 1'b1, 4'b0100);
    cyc(1'b0, 1'b1, 4'b0110, 1'b1, 4'b0111);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0100);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1100);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1100);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0111);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0001);

    // Pacing: accept without shift_en, then shift_en once every 3 clks -> 12-clk frame.
    cyc(1'b0, 1'b1, 4'b1001, 1'b0, 4'b0001);
    w = 4'b1001;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      for (int p = 0; p < 3; p++) begin
        se_v = (p == 2);
        cyc(1'b0, 1'b0, 4'b0000, se_v,
            {w[k], 1'b1, (k == 0), ((k == 0) && se_v)});
      end
    end
    cyc(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0001);

    // Backpressure: 1111 offered mid-frame of 1000, taken only on the last-bit edge.
    cyc(1'b0, 1'b1, 4'b1000, 1'b1, 4'b0001);
    cyc(1'b0, 1'b1, 4'b1111, 1'b1, 4'b1100);
    cyc(1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100);
    cyc(1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100);
    cyc(1'b0, 1'b1, 4'b1111, 1'b1, 4'b0111);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1100);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1100);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1100);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1111);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0001);

    // Reset during bit 2 of 1010 with a competing load_valid; then a clean 0001 frame.
    cyc(1'b0, 1'b1, 4'b1010, 1'b1, 4'b0001);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1100);
    cyc(1'b1, 1'b1, 4'b1111, 1'b1, 4'b0100);
    cyc(1'b0, 1'b1, 4'b0001, 1'b1, 4'b0001);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0100);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0100);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0100);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1111);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0001);

    // Idle hygiene: shift_en toggling with no load leaves the line quiet.
    cyc(1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001);
    cyc(1'b0, 1'b0, 4'b1111, 1'b0, 4'b0001);
    cyc(1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001);
    cyc(1'b0, 1'b0, 4'b1111, 1'b0, 4'b0001);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
